// File: rtl/la_mem_pkg.sv
// Shared definitions for the capture memory path.
// Holds the default BRAM geometry, the single-port grant encoding and a helper
// that turns an address width into a sample capacity.
package la_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 18;
    localparam int unsigned DEF_DATA_W = 8;

    // Which requester owns the BRAM port in a given cycle.
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CAP,
        GNT_RD
    } gnt_e;

    function automatic int unsigned capacity(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    localparam int unsigned CAPACITY = capacity(DEF_ADDR_W);

endpackage

// File: rtl/rd_resp_pipe.sv
// Read response pipeline for the capture BRAM.
// Tracks in-flight reads with a valid shift register and captures the BRAM
// read data into a response register so responses leave in issue order.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   rd_issue    - a read is presented on the BRAM port this cycle
//   ram_rdata   - BRAM read data, valid RD_LAT cycles after rd_issue
//   rsp_valid   - one-cycle response strobe
//   rsp_data    - response data, valid with rsp_valid
// RD_LAT must be at least 1.
module rd_resp_pipe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_issue,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data
);

    // vld_q[k] marks a read whose enable was seen k+1 cycles ago.
    logic [RD_LAT:0]   vld_q;
    logic [DATA_W-1:0] rsp_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            vld_q <= {vld_q[RD_LAT-1:0], rd_issue};
            // BRAM output is valid for the stage RD_LAT-1; latch it on the way out.
            if (vld_q[RD_LAT-1]) begin
                rsp_data_q <= ram_rdata;
            end
        end
    end

    assign rsp_valid = vld_q[RD_LAT];
    assign rsp_data  = rsp_data_q;

endmodule

// File: rtl/capture_mem_arbiter.sv
// Single-port owner of the capture BRAM.
// Arbitrates the port between the capture write stream and host readback,
// generates the write address from a fill counter and reports fill status.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   clr                   - synchronous clear of fill counter, overflow, streak
//   cap_valid/data/ready  - capture write stream (ready is combinational)
//   rd_valid/addr/ready   - host read requests (ready is combinational)
//   rsp_valid/data        - in-order read responses, no backpressure
//   wr_count, full        - samples written since clear, memory full
//   overflow              - sticky, a sample was offered while full
//   ram_*                 - registered BRAM port, ram_rdata from the BRAM
module capture_mem_arbiter
    import la_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              cap_valid,
    input  logic [DATA_W-1:0] cap_data,
    output logic              cap_ready,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W:0]   wr_count,
    output logic              full,
    output logic              overflow,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned CNT_W    = ADDR_W + 1;
    localparam int unsigned STREAK_W = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0]    FULL_COUNT   = CNT_W'(capacity(ADDR_W));
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(STARVE_MAX);

    logic [CNT_W-1:0]    wr_count_q;
    logic [STREAK_W-1:0] streak_q;
    logic                overflow_q;
    logic                ram_en_q;
    logic                ram_we_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_wdata_q;

    logic is_full;
    logic starved;
    logic cap_req;
    logic rd_req;
    gnt_e gnt;

    always_comb begin
        is_full = (wr_count_q == FULL_COUNT);
        starved = (streak_q == STREAK_LIMIT);
        // clr and reset both suppress every grant in their cycle.
        cap_req = cap_valid && !is_full && !clr && !reset;
        rd_req  = rd_valid && !clr && !reset;

        gnt = GNT_NONE;
        if (cap_req && !(rd_req && starved)) begin
            gnt = GNT_CAP;
        end else if (rd_req) begin
            gnt = GNT_RD;
        end
    end

    assign cap_ready = (gnt == GNT_CAP);
    assign rd_ready  = (gnt == GNT_RD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count_q  <= '0;
            streak_q    <= '0;
            overflow_q  <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_en_q <= (gnt != GNT_NONE);
            ram_we_q <= (gnt == GNT_CAP);

            // Address and write data hold when the port is idle.
            if (gnt == GNT_CAP) begin
                ram_addr_q  <= wr_count_q[ADDR_W-1:0];
                ram_wdata_q <= cap_data;
                wr_count_q  <= wr_count_q + CNT_W'(1);
            end else if (gnt == GNT_RD) begin
                ram_addr_q <= rd_addr;
            end

            if (clr) begin
                wr_count_q <= '0;
                streak_q   <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (cap_valid && is_full) begin
                    overflow_q <= 1'b1;
                end
                // Streak counts writes that overtook a waiting read.
                if (!rd_valid || gnt == GNT_RD) begin
                    streak_q <= '0;
                end else if (gnt == GNT_CAP) begin
                    streak_q <= streak_q + STREAK_W'(1);
                end
            end
        end
    end

    assign wr_count  = wr_count_q;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

    rd_resp_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_resp_pipe (
        .clk       (clk),
        .reset     (reset),
        .rd_issue  (ram_en_q && !ram_we_q),
        .ram_rdata (ram_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

endmodule
